verificador_vitoria: RTL and testbench
======================================

# verificador_vitoria

Sequential win/draw checker for the ultimate tic-tac-toe datapath. It is the read side of the board RAMs the control unit writes: on a start pulse it reads the 9 cells of one 3x3 board (a micro board or the macro state board) through a synchronous-read port. It then evaluates the 8 lines for the latched player and reports a registered result code. The control unit consumes `vitoria`/`resultado` in its verify states, and in macro mode uses `vitoria` as its end-of-game flag.

## Interface
Parameters:
- `CELL_W`, 2: bits per cell. Encoding: 00 empty, 01 player 0, 10 player 1, 11 drawn (macro board only).

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `iniciar`  in  1: start pulse; sampled only in OCIOSO.
- `jogador`  in  1: current player; latched when `iniciar` is accepted.
- `modo_macro`  in  1: 1 reads the macro state RAM, 0 reads the micro board RAM; latched when `iniciar` is accepted.
- `tabuleiro`  in  4: micro board index 0..8; latched when `iniciar` is accepted; ignored when `modo_macro`=1.
- `rd_en`  out  1: read strobe.
- `rd_sel_macro`  out  1: RAM select; equals the latched `modo_macro` while `rd_en`=1, else 0.
- `rd_addr`  out  7: read address. Micro mode: 9*tabuleiro + cell (0..80). Macro mode: cell (0..8).
- `rd_data`  in  CELL_W: read data, valid the cycle after `rd_en`.
- `ocupado`  out  1: high in every state except OCIOSO.
- `pronto`  out  1: one-cycle completion pulse.
- `vitoria`  out  1: latched player owns a complete line.
- `empate`  out  1: no win for the latched player and no empty cell.
- `resultado`  out  2: 01/10 = win for player 0/1, 11 = draw, 00 = undecided.
- `db_estado`  out  3: current state code, for debug.

## Operation
- Cell index c = 3*row + col. Lines checked: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
- Player code P = `jogador` ? 10 : 01. A line is won only if all three cells equal P. Cells holding 11 or the opponent's code block the line.
- The block never evaluates the opponent's win; only the latched player can have just moved.
- `empate` = !`vitoria` && no cell == 00. `vitoria` and `empate` are never both 1.
- `resultado` = `vitoria` ? P : (`empate` ? 11 : 00).
- States:
  - OCIOSO (0): wait for `iniciar`. On accept, latch inputs, clear the cell counter and the 18-bit cell shift register.
  - LEITURA (1): `rd_en`=1 and `rd_addr`=base + cell counter; counter increments each cycle. Leave after cell 8 is issued.
  - ESPERA (2): capture the last read datum.
  - AVALIA (3): compute lines, register `vitoria`/`empate`/`resultado`.
  - FIM (4): `pronto`=1; next state OCIOSO.
  - Unused codes return to OCIOSO.
- Capture: `rd_data` is shifted into cell slot c at the edge one cycle after the address for c was presented, in LEITURA (cells 0..7) and ESPERA (cell 8).
- Result outputs hold their values from the AVALIA edge until the next AVALIA. A new `iniciar` does not clear them.
- `iniciar` while `ocupado`=1 is ignored; no queuing.
- Address arithmetic: 9*tabuleiro is computed as (tabuleiro<<3)+tabuleiro in 7 bits. `tabuleiro` > 8 is illegal; the address is truncated to 7 bits and no error is flagged.

## Timing
- Reset values: state OCIOSO; `rd_en`, `rd_sel_macro`, `rd_addr`, `ocupado`, `pronto`, `vitoria`, `empate`, `resultado` all 0; `db_estado`=0.
- Reset mid-operation aborts immediately. No further `rd_en`; results are cleared.
- Call the edge that samples `iniciar`=1 E0:
  - `rd_en`=1 in cycles 1..9, with addresses cell 0..8 in order.
  - Data for cell c is captured at edge E(c+2).
  - ESPERA is cycle 10, AVALIA cycle 11, FIM cycle 12.
  - `pronto`=1 in cycle 12 only, and results are already valid in that cycle.
  - The earliest next accepted `iniciar` is sampled at E13. Total turnaround is 13 cycles.
- `ocupado`=1 in cycles 1..12.

## Test plan
- Reset during LEITURA (cycle 5) → `rd_en`=0 next cycle, all outputs 0, state OCIOSO; a following `iniciar` runs a normal 13-cycle sequence.
- Micro mode, `tabuleiro`=4, `jogador`=0, cells {0,1,2}=01, rest 00 → addresses 36..44 in cycles 1..9; cycle 12: `pronto`=1, `vitoria`=1, `resultado`=01, `empate`=0.
- Micro mode, `tabuleiro`=8, `jogador`=1, diagonal {2,4,6}=10, cells {0,1}=01 → addresses 72..80; `vitoria`=1, `resultado`=10.
- Full board, no line for `jogador`=0, pattern 01,10,01,01,10,10,10,01,01 → `empate`=1, `resultado`=11, `vitoria`=0.
- Macro mode, `jogador`=1, cells {0,3,6} = 10,11,10, rest 00 → `rd_sel_macro`=1 and addresses 0..8; column blocked by 11 → `vitoria`=0, `empate`=0, `resultado`=00.
- Player mismatch: `jogador`=1, cells {0,1,2}=01 → `vitoria`=0. A second `iniciar` pulsed in cycle 6 is ignored: exactly 9 `rd_en` cycles and one `pronto`.

Source files
------------

// File: rtl/verificador_vitoria.sv
`default_nettype none
// ============================================================================
// Module   : verificador_vitoria
// Purpose  : Sequential win/draw checker for one 3x3 board (micro board or
//            macro state board). On a start pulse it reads the 9 cells over a
//            synchronous-read RAM port. It then checks the 8 lines for the
//            latched player and registers a result code.
// Ports    : clock, reset          - rising-edge clock, async active-high reset
//            iniciar               - start pulse (accepted only when idle)
//            jogador, modo_macro,
//            tabuleiro             - player, RAM select, micro board index
//            rd_en, rd_sel_macro,
//            rd_addr, rd_data      - board RAM read port (data valid 1 cycle
//                                    after rd_en)
//            ocupado, pronto       - busy flag, one-cycle completion pulse
//            vitoria, empate,
//            resultado             - registered result (held until next check)
//            db_estado             - current state code
// Revision : 1.0 - initial release
// ============================================================================
module verificador_vitoria #(
  parameter int CELL_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogador,
  input  logic              modo_macro,
  input  logic [3:0]        tabuleiro,
  output logic              rd_en,
  output logic              rd_sel_macro,
  output logic [6:0]        rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic              ocupado,
  output logic              pronto,
  output logic              vitoria,
  output logic              empate,
  output logic [1:0]        resultado,
  output logic [2:0]        db_estado
);

  localparam logic [2:0] c_OCIOSO  = 3'd0;
  localparam logic [2:0] c_LEITURA = 3'd1;
  localparam logic [2:0] c_ESPERA  = 3'd2;
  localparam logic [2:0] c_AVALIA  = 3'd3;
  localparam logic [2:0] c_FIM     = 3'd4;

  localparam int c_CELLS_W = 9 * CELL_W;

  logic [2:0]           r_estado;
  logic [2:0]           w_prox;
  logic [3:0]           r_cont;
  logic [c_CELLS_W-1:0] r_celulas;
  logic                 r_jog;
  logic                 r_macro;
  logic [3:0]           r_tab;
  logic                 r_vitoria;
  logic                 r_empate;
  logic [1:0]           r_resultado;

  logic [6:0]           w_base;
  logic [CELL_W-1:0]    w_p;
  logic [1:0]           w_codigo;
  logic [8:0]           w_eq;
  logic [8:0]           w_ocup;
  logic                 w_vit;
  logic                 w_emp;

  // 9*tabuleiro as (t<<3)+t, truncated to 7 bits; macro board sits at 0.
  assign w_base = r_macro ? 7'd0 : ({r_tab, 3'b000} + {3'b000, r_tab});

  assign w_p      = r_jog ? CELL_W'(2) : CELL_W'(1);
  assign w_codigo = r_jog ? 2'b10 : 2'b01;

  // Cell 0 ends up in the lowest slot because cells are shifted in from the
  // top in address order.
  for (genvar i = 0; i < 9; i++) begin : g_cell
    logic [CELL_W-1:0] w_cell;
    assign w_cell  = r_celulas[i*CELL_W +: CELL_W];
    assign w_eq[i]   = (w_cell == w_p);
    assign w_ocup[i] = (w_cell != '0);
  end

  assign w_vit = (w_eq[0] & w_eq[1] & w_eq[2]) |
                 (w_eq[3] & w_eq[4] & w_eq[5]) |
                 (w_eq[6] & w_eq[7] & w_eq[8]) |
                 (w_eq[0] & w_eq[3] & w_eq[6]) |
                 (w_eq[1] & w_eq[4] & w_eq[7]) |
                 (w_eq[2] & w_eq[5] & w_eq[8]) |
                 (w_eq[0] & w_eq[4] & w_eq[8]) |
                 (w_eq[2] & w_eq[4] & w_eq[6]);
  assign w_emp = !w_vit && (&w_ocup);

  always_comb begin
    w_prox = c_OCIOSO;
    case (r_estado)
      c_OCIOSO:  w_prox = iniciar ? c_LEITURA : c_OCIOSO;
      c_LEITURA: w_prox = (r_cont == 4'd8) ? c_ESPERA : c_LEITURA;
      c_ESPERA:  w_prox = c_AVALIA;
      c_AVALIA:  w_prox = c_FIM;
      c_FIM:     w_prox = c_OCIOSO;
      default:   w_prox = c_OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= c_OCIOSO;
      r_cont      <= 4'd0;
      r_celulas   <= '0;
      r_jog       <= 1'b0;
      r_macro     <= 1'b0;
      r_tab       <= 4'd0;
      r_vitoria   <= 1'b0;
      r_empate    <= 1'b0;
      r_resultado <= 2'b00;
    end else begin
      r_estado <= w_prox;
      case (r_estado)
        c_OCIOSO: begin
          if (iniciar) begin
            r_jog     <= jogador;
            r_macro   <= modo_macro;
            r_tab     <= tabuleiro;
            r_cont    <= 4'd0;
            r_celulas <= '0;
          end
        end
        c_LEITURA: begin
          r_cont <= r_cont + 4'd1;
          // Data for the address issued last cycle arrives now; nothing is
          // in flight while the first address is out.
          if (r_cont != 4'd0) begin
            r_celulas <= {rd_data, r_celulas[c_CELLS_W-1:CELL_W]};
          end
        end
        c_ESPERA: begin
          r_celulas <= {rd_data, r_celulas[c_CELLS_W-1:CELL_W]};
        end
        c_AVALIA: begin
          r_vitoria   <= w_vit;
          r_empate    <= w_emp;
          r_resultado <= w_vit ? w_codigo : (w_emp ? 2'b11 : 2'b00);
        end
        default: ;
      endcase
    end
  end

  assign rd_en        = (r_estado == c_LEITURA);
  assign rd_sel_macro = rd_en & r_macro;
  assign rd_addr      = rd_en ? (w_base + {3'b000, r_cont}) : 7'd0;
  assign ocupado      = (r_estado != c_OCIOSO);
  assign pronto       = (r_estado == c_FIM);
  assign vitoria      = r_vitoria;
  assign empate       = r_empate;
  assign resultado    = r_resultado;
  assign db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_verificador_vitoria.sv
`default_nettype none
// ============================================================================
// Module   : tb_verificador_vitoria
// Purpose  : Directed self-checking bench for verificador_vitoria with a
//            synchronous-read model of the micro and macro board RAMs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_verificador_vitoria;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogador = 1'b0;
  logic       modo_macro = 1'b0;
  logic [3:0] tabuleiro = 4'd0;
  logic       rd_en;
  logic       rd_sel_macro;
  logic [6:0] rd_addr;
  logic [1:0] rd_data = 2'b00;
  logic       ocupado;
  logic       pronto;
  logic       vitoria;
  logic       empate;
  logic [1:0] resultado;
  logic [2:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] micro_mem [0:127];
  logic [1:0] macro_mem [0:127];

  verificador_vitoria #(.CELL_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogador      (jogador),
    .modo_macro   (modo_macro),
    .tabuleiro    (tabuleiro),
    .rd_en        (rd_en),
    .rd_sel_macro (rd_sel_macro),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .vitoria      (vitoria),
    .empate       (empate),
    .resultado    (resultado),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous-read board RAMs.
  always @(posedge clock) begin
    if (rd_en) rd_data <= rd_sel_macro ? macro_mem[rd_addr] : micro_mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] board(input logic [1:0] c0, c1, c2, c3, c4,
                                        c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic load(input bit macro, input int base, input logic [17:0] pat);
    for (int c = 0; c < 9; c++) begin
      if (macro) macro_mem[c] = pat[2*c +: 2];
      else       micro_mem[base + c] = pat[2*c +: 2];
    end
  endtask

  // One full check sequence; k counts cycles after the edge that samples iniciar.
  task automatic run(input string nm, input logic jog, input logic macro,
                     input logic [3:0] tab, input logic [6:0] base,
                     input logic evit, input logic eemp, input logic [1:0] eres,
                     input bit pulse6);
    int nrd = 0;
    int npr = 0;
    @(negedge clock);
    jogador = jog; modo_macro = macro; tabuleiro = tab; iniciar = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == 1 || k == 7) iniciar = 1'b0;
      if (rd_en)  nrd++;
      if (pronto) npr++;
      check({nm, ":rd_en"}, rd_en, (k <= 9));
      if (k <= 9) begin
        check({nm, ":rd_addr"}, rd_addr, base + k - 1);
        check({nm, ":rd_sel_macro"}, rd_sel_macro, macro);
      end
      check({nm, ":ocupado"}, ocupado, (k <= 12));
      if (k == 10) check({nm, ":estado_espera"}, db_estado, 2);
      if (k == 11) check({nm, ":estado_avalia"}, db_estado, 3);
      if (k == 12) begin
        check({nm, ":pronto"}, pronto, 1);
        check({nm, ":vitoria"}, vitoria, evit);
        check({nm, ":empate"}, empate, eemp);
        check({nm, ":resultado"}, resultado, eres);
      end
      if (k == 14) check({nm, ":resultado_hold"}, resultado, eres);
      if (pulse6 && k == 6) iniciar = 1'b1;
    end
    check({nm, ":n_rd_en"}, nrd, 9);
    check({nm, ":n_pronto"}, npr, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      micro_mem[i] = 2'b00;
      macro_mem[i] = 2'b00;
    end

    // Reset state
    repeat (2) @(negedge clock);
    check("rst:rd_en", rd_en, 0);
    check("rst:rd_addr", rd_addr, 0);
    check("rst:ocupado", ocupado, 0);
    check("rst:pronto", pronto, 0);
    check("rst:resultado", resultado, 0);
    check("rst:db_estado", db_estado, 0);
    reset = 1'b0;

    // Micro tab 4, player 0, top row
    load(0, 36, board(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    run("t1", 0, 0, 4'd4, 7'd36, 1, 0, 2'b01, 0);

    // Reset in cycle 5 of a check aborts and clears results
    @(negedge clock);
    tabuleiro = 4'd3; jogador = 0; modo_macro = 0; iniciar = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      iniciar = 1'b0;
    end
    check("rstmid:rd_en_before", rd_en, 1);
    reset = 1'b1;
    #1;
    check("rstmid:rd_en_async", rd_en, 0);
    @(negedge clock);
    check("rstmid:rd_en", rd_en, 0);
    check("rstmid:ocupado", ocupado, 0);
    check("rstmid:vitoria", vitoria, 0);
    check("rstmid:resultado", resultado, 0);
    check("rstmid:db_estado", db_estado, 0);
    reset = 1'b0;

    // Micro tab 8, player 1, anti-diagonal
    load(0, 72, board(2'b01, 2'b01, 2'b10, 0, 2'b10, 0, 2'b10, 0, 0));
    run("t2", 1, 0, 4'd8, 7'd72, 1, 0, 2'b10, 0);

    // Full board, no line for player 0 -> draw
    load(0, 0, board(2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01));
    run("t3", 0, 0, 4'd0, 7'd0, 0, 1, 2'b11, 0);

    // Macro mode; micro cells 0..8 hold a player-1 win to expose a wrong select
    load(0, 0, board(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10));
    load(1, 0, board(2'b10, 0, 0, 2'b11, 0, 0, 2'b10, 0, 0));
    run("t4", 1, 1, 4'd5, 7'd0, 0, 0, 2'b00, 0);

    // Player mismatch, second iniciar in cycle 6 ignored
    load(0, 18, board(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    run("t5", 1, 0, 4'd2, 7'd18, 0, 0, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
